// File: rtl/pong_pkg.sv
// Shared types and default widths for the pong ball engine.
package pong_pkg;

   localparam int COORD_W_DEF = 10;
   localparam int SPEED_W_DEF = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [1:0] PH_NONE = 2'b00;
   localparam logic [1:0] PH_P1   = 2'b01;
   localparam logic [1:0] PH_P2   = 2'b10;

endpackage

// File: rtl/score_counter.sv
// One player's score: synchronous clear, increment, and a flag that the value
// about to be written equals the winning score.
module score_counter #(
   parameter int SCORE_W   = 4,
   parameter int MAX_SCORE = 9
) (
   input  logic               bclk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [SCORE_W-1:0] count,
   output logic               reach_max
);

   logic [SCORE_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge bclk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign reach_max = (count_d == SCORE_W'(MAX_SCORE));

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve/play/point FSM, ball motion with wall and paddle
// bounces, speed-up after repeated paddle hits, and per-player scoring.
module ball_engine
   import pong_pkg::*;
#(
   parameter int COORD_W     = COORD_W_DEF,
   parameter int FIELD_W     = 640,
   parameter int FIELD_H     = 360,
   parameter int X_MIN       = 2,
   parameter int Y_MIN       = 5,
   parameter int X_DEF       = 20,
   parameter int Y_DEF       = 20,
   parameter int SPEED_W     = SPEED_W_DEF,
   parameter int SERVE_TICKS = 60,
   parameter int SCORE_W     = 4,
   parameter int MAX_SCORE   = 9,
   parameter int HITS_PER_UP = 4
) (
   input  logic               bclk,
   input  logic               reset,
   input  logic               step,
   input  logic               serve,
   input  logic [SPEED_W-1:0] speed_init,
   input  logic [COORD_W-1:0] paddle1_x1,
   input  logic [COORD_W-1:0] paddle1_x2,
   input  logic [COORD_W-1:0] paddle2_x1,
   input  logic [COORD_W-1:0] paddle2_x2,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [SPEED_W-1:0] ball_speed,
   output logic [2:0]         state,
   output logic               ball_sound,
   output logic [1:0]         paddle_hit,
   output logic               point_p1,
   output logic               point_p2,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               game_over
);

   localparam int CW    = COORD_W + 1;
   localparam int SRV_W = (SERVE_TICKS > 0) ? $clog2(SERVE_TICKS + 1) : 1;
   localparam int HIT_W = $clog2(HITS_PER_UP + 1);
   localparam logic [CW-1:0] X_LO = CW'(X_MIN);
   localparam logic [CW-1:0] X_HI = CW'(FIELD_W - 4);
   localparam logic [CW-1:0] Y_LO = CW'(Y_MIN);
   localparam logic [CW-1:0] Y_HI = CW'(FIELD_H - 5);
   localparam logic [SPEED_W-1:0] SPD_MAX = '1;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               xdir_q, xdir_d, ydir_q, ydir_d;   // 1 = coordinate increasing
   logic [SPEED_W-1:0] spd_q, spd_d, spd_init;
   logic [SRV_W-1:0]   srv_q, srv_d;
   logic [HIT_W-1:0]   hits_q, hits_d;
   logic               sound_q, sound_d, pt1_q, pt1_d, pt2_q, pt2_d, over_q, over_d;
   logic [1:0]         phit_q, phit_d;
   logic               p1_scored_q, p1_scored_d;
   logic               score_clr, rally_reset;
   logic [1:0]         score_inc, score_max;
   logic [SCORE_W-1:0] score_val [2];
   logic [CW-1:0]      xw, yw, sw;
   logic               y_hit, y_miss, x_bounce;

   assign spd_init = (speed_init == '0) ? SPEED_W'(1) : speed_init;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      xdir_d      = xdir_q;
      ydir_d      = ydir_q;
      spd_d       = spd_q;
      srv_d       = srv_q;
      hits_d      = hits_q;
      over_d      = over_q;
      p1_scored_d = p1_scored_q;
      sound_d     = 1'b0;
      phit_d      = PH_NONE;
      pt1_d       = 1'b0;
      pt2_d       = 1'b0;
      score_clr   = 1'b0;
      score_inc   = 2'b00;
      rally_reset = 1'b0;
      y_hit       = 1'b0;
      y_miss      = 1'b0;
      x_bounce    = 1'b0;
      xw          = CW'(x_q);
      yw          = CW'(y_q);
      sw          = CW'(spd_q);

      case (state_q)
         S_IDLE: if (serve) begin
            srv_d   = SRV_W'(SERVE_TICKS);
            state_d = S_SERVE;
         end
         S_SERVE: if (step) begin
            if (srv_q == '0) state_d = S_PLAY;
            else             srv_d   = srv_q - 1'b1;
         end
         S_PLAY: if (step) begin
            // Paddle lines: the pre-update x decides hit versus miss.
            if (!ydir_q && yw <= Y_LO + sw) begin
               if (xw >= CW'(paddle1_x1) && xw <= CW'(paddle1_x2)) begin
                  y_hit  = 1'b1;
                  y_d    = COORD_W'(Y_MIN);
                  phit_d = PH_P1;
               end else begin
                  y_miss      = 1'b1;
                  p1_scored_d = 1'b0;
               end
            end else if (ydir_q && yw + sw >= Y_HI) begin
               if (xw >= CW'(paddle2_x1) && xw <= CW'(paddle2_x2)) begin
                  y_hit  = 1'b1;
                  y_d    = COORD_W'(FIELD_H - 5);
                  phit_d = PH_P2;
               end else begin
                  y_miss      = 1'b1;
                  p1_scored_d = 1'b1;
               end
            end else begin
               y_d = ydir_q ? COORD_W'(yw + sw) : COORD_W'(yw - sw);
            end

            if (y_miss) begin
               y_d     = y_q;
               state_d = S_POINT;
            end else begin
               if (!xdir_q && xw <= X_LO + sw) begin
                  x_d      = COORD_W'(X_MIN);
                  x_bounce = 1'b1;
               end else if (xdir_q && xw + sw >= X_HI) begin
                  x_d      = COORD_W'(FIELD_W - 4);
                  x_bounce = 1'b1;
               end else begin
                  x_d = xdir_q ? COORD_W'(xw + sw) : COORD_W'(xw - sw);
               end
               if (x_bounce) xdir_d = !xdir_q;
               if (y_hit)    ydir_d = !ydir_q;
               sound_d = x_bounce | y_hit;
               if (y_hit) begin
                  if (hits_q + 1'b1 == HIT_W'(HITS_PER_UP)) begin
                     hits_d = '0;
                     if (spd_q != SPD_MAX) spd_d = spd_q + 1'b1;
                  end else begin
                     hits_d = hits_q + 1'b1;
                  end
               end
            end
         end
         S_POINT: begin
            score_inc = {!p1_scored_q, p1_scored_q};
            pt1_d     = p1_scored_q;
            pt2_d     = !p1_scored_q;
            if (|(score_inc & score_max)) begin
               state_d = S_OVER;
               over_d  = 1'b1;
            end else begin
               state_d     = S_IDLE;
               rally_reset = 1'b1;
            end
         end
         S_OVER: if (serve) begin
            score_clr   = 1'b1;
            over_d      = 1'b0;
            srv_d       = SRV_W'(SERVE_TICKS);
            state_d     = S_SERVE;
            rally_reset = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // New rally heads toward whoever conceded the last point.
      if (rally_reset) begin
         x_d    = COORD_W'(X_DEF);
         y_d    = COORD_W'(Y_DEF);
         xdir_d = 1'b1;
         ydir_d = p1_scored_q;
         spd_d  = spd_init;
         hits_d = '0;
      end
   end

   always_ff @(posedge bclk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= COORD_W'(X_DEF);
         y_q         <= COORD_W'(Y_DEF);
         xdir_q      <= 1'b1;
         ydir_q      <= 1'b1;
         spd_q       <= spd_init;
         srv_q       <= '0;
         hits_q      <= '0;
         sound_q     <= 1'b0;
         phit_q      <= PH_NONE;
         pt1_q       <= 1'b0;
         pt2_q       <= 1'b0;
         over_q      <= 1'b0;
         p1_scored_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         xdir_q      <= xdir_d;
         ydir_q      <= ydir_d;
         spd_q       <= spd_d;
         srv_q       <= srv_d;
         hits_q      <= hits_d;
         sound_q     <= sound_d;
         phit_q      <= phit_d;
         pt1_q       <= pt1_d;
         pt2_q       <= pt2_d;
         over_q      <= over_d;
         p1_scored_q <= p1_scored_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_score
         score_counter #(
            .SCORE_W  (SCORE_W),
            .MAX_SCORE(MAX_SCORE)
         ) u_score (
            .bclk     (bclk),
            .reset    (reset),
            .clr      (score_clr),
            .inc      (score_inc[gi]),
            .count    (score_val[gi]),
            .reach_max(score_max[gi])
         );
      end
   endgenerate

   assign ball_x     = x_q;
   assign ball_y     = y_q;
   assign ball_speed = spd_q;
   assign state      = state_q;
   assign ball_sound = sound_q;
   assign paddle_hit = phit_q;
   assign point_p1   = pt1_q;
   assign point_p2   = pt2_q;
   assign score1     = score_val[0];
   assign score2     = score_val[1];
   assign game_over  = over_q;

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows, one per line:
  COORD_W, 10, coordinate width
  FIELD_W, 640, field width in pixels
  FIELD_H, 360, field height in pixels
  X_MIN, 2, left wall
  Y_MIN, 5, paddle-1 line
  X_DEF, 20, serve x
  Y_DEF, 20, serve y
  SPEED_W, 3, speed width
  SERVE_TICKS, 60, serve delay in steps
  SCORE_W, 4, score width
  MAX_SCORE, 9, winning score
  HITS_PER_UP, 4, paddle hits per speed-up
REQ-002 Clock and reset: reset, synchronous, active-high; clock bclk.
REQ-003 Ports (name direction width meaning) SHALL be as follows, one per line:
  bclk in 1 clock
  reset in 1 sync reset
  step in 1 motion enable (one frame)
  serve in 1 serve/restart request
  speed_init in SPEED_W initial speed
  paddle1_x1/paddle1_x2 in COORD_W paddle-1 span (inclusive)
  paddle2_x1/paddle2_x2 in COORD_W paddle-2 span (inclusive)
  ball_x/ball_y out COORD_W position
  ball_speed out SPEED_W current speed
  state out 3 FSM state
  ball_sound out 1 bounce pulse
  paddle_hit out 2 01=p1, 10=p2, else 00
  point_p1/point_p2 out 1 point pulse
  score1/score2 out SCORE_W scores
  game_over out 1 match finished

Function
REQ-004 FSM states SHALL be IDLE, SERVE, PLAY, POINT and OVER; serve SHALL be ignored in SERVE, PLAY and POINT.
REQ-005 IDLE SHALL move to SERVE on serve, loading the serve counter with SERVE_TICKS.
REQ-006 SERVE SHALL decrement the counter on each step and move to PLAY on a step seen with the counter at 0.
REQ-007 In PLAY, each step SHALL move the ball by ball_speed on both axes; without step, position SHALL hold.
REQ-008 Wall and paddle comparisons SHALL be done at COORD_W+1 bits; the ball SHALL never wrap or overshoot a limit.
REQ-009 X axis moving down with x <= X_MIN+spd: x SHALL become X_MIN, direction SHALL flip to up, and ball_sound SHALL pulse.
REQ-010 X axis moving up with x+spd >= FIELD_W-4: x SHALL become FIELD_W-4, direction SHALL flip to down, and ball_sound SHALL pulse.
REQ-011 Y axis moving down with y <= Y_MIN+spd: if paddle1_x1 <= x <= paddle1_x2 (pre-update x), the block SHALL set y=Y_MIN, flip direction, set paddle_hit=01 and pulse ball_sound; otherwise it SHALL register a miss and score player 2.
REQ-012 Y axis moving up with y+spd >= FIELD_H-5: the block SHALL apply the same rule as REQ-011 with paddle2, setting paddle_hit=10 on a hit; a miss SHALL score player 1.
REQ-013 On a miss, position SHALL freeze, no sound SHALL be produced, the x update SHALL be suppressed, and the FSM SHALL go to POINT.
REQ-014 On a simultaneous X and Y bounce, both SHALL apply in the same step with a single one-cycle ball_sound.
REQ-015 Every HITS_PER_UP paddle hits SHALL increment speed, saturating at 2^SPEED_W-1, and SHALL clear the hit counter.
REQ-016 POINT (one cycle) SHALL increment the scorer's score and pulse point_pX; if the new score equals MAX_SCORE the FSM SHALL go to OVER, otherwise to IDLE.
REQ-017 On the POINT-to-IDLE transition, the ball SHALL be placed at (X_DEF, Y_DEF), x direction SHALL be up, y direction SHALL point toward the conceding player, speed SHALL be reloaded and the hit counter cleared.
REQ-018 OVER SHALL hold game_over=1 and frozen outputs; serve in OVER SHALL clear scores and game_over, reset the ball per REQ-017, and enter SERVE.
REQ-019 speed_init=0 SHALL be treated as 1.
REQ-020 All outputs SHALL be registered and SHALL reflect a step one cycle after the step cycle; ball_sound, paddle_hit and point_pX SHALL be single-cycle pulses.

Reset
REQ-021 Reset SHALL override all activity in any state, including mid-PLAY and mid-SERVE.
REQ-022 Reset values SHALL be: state=IDLE, ball=(X_DEF,Y_DEF), both directions up, speed=max(speed_init,1), scores=0, hit and serve counters=0, all pulses=0, game_over=0.

Structure
REQ-023 Package pong_pkg SHALL hold the FSM state enum, the paddle_hit codes and the default COORD_W and SPEED_W values.
REQ-024 A sub-module score_counter (synchronous clear, increment, equality-to-MAX_SCORE flag) SHALL be instantiated once per player.

Verification
REQ-025 Reset, serve, then SERVE_TICKS+1 steps -> state=PLAY; first PLAY step with speed 1 -> ball (21,21).
REQ-026 speed_init=3, ball moving down at x=4 -> x=2 and one-cycle ball_sound=1.
REQ-027 Ball reaches y<=Y_MIN+spd moving down with x=100 and paddle1 at 90..130 -> y=5, paddle_hit=01; repeat with paddle1 at 200..240 -> point_p2=1, score2=1, state IDLE.
REQ-028 Four consecutive paddle hits at speed 2 -> ball_speed=3; at speed 7 -> ball_speed stays 7.
REQ-029 Player 1 scores 9 points -> game_over=1 and state=OVER; serve -> scores=0 and state=SERVE.
REQ-030 Assert reset during PLAY with ball at (300,200) -> next cycle ball (20,20), state IDLE, all pulses 0.
